// File: rtl/dh_pkg.sv
// Shared definitions for the challenge/response side of the key exchange:
// responder state encoding, default sizing and timeout-counter width helper.
package dh_pkg;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_KEY_TO = 15;
    localparam int DEF_ACK_TO = 15;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_KEY = 3'd1,
        CALC     = 3'd2,
        SEND     = 3'd3,
        ERR      = 3'd4
    } state_e;

    // Bits needed to hold the larger of the two timeout limits.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/challenge_responder.sv
// Answers a challenge with c2 = challenge XOR key; c2_vld_o rises two edges after an accepted challenge.
// c2_vld_o/c2_o hold until c2_ack_i or ACK_TO cycles in SEND; challenges arriving while busy are dropped.
module challenge_responder
    import dh_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int KEY_TO = DEF_KEY_TO,
    parameter int ACK_TO = DEF_ACK_TO
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] key_i,
    input  logic             key_vld_i,
    input  logic [WIDTH-1:0] chal_i,
    input  logic             chal_vld_i,
    output logic [WIDTH-1:0] c2_o,
    output logic             c2_vld_o,
    input  logic             c2_ack_i,
    output logic             busy_o,
    output logic             drop_o,
    output logic             err_o,
    output logic [7:0]       resp_cnt_o
);

    localparam int            CW       = cnt_width(KEY_TO, ACK_TO);
    localparam logic [CW-1:0] KEY_LAST = CW'(KEY_TO - 1);
    localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TO - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] key_q, key_d;
    logic [WIDTH-1:0] chal_q, chal_d;
    logic [WIDTH-1:0] c2_q, c2_d;
    logic             key_loaded_q, key_loaded_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c2_vld_q, c2_vld_d;
    logic             busy_q, busy_d;
    logic             drop_q, drop_d;
    logic             err_q, err_d;
    logic [7:0]       resp_cnt_q, resp_cnt_d;

    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        key_loaded_d = key_loaded_q;
        chal_d       = chal_q;
        c2_d         = c2_q;
        cnt_d        = '0;
        c2_vld_d     = 1'b0;
        resp_cnt_d   = resp_cnt_q;
        drop_d       = chal_vld_i && (state_q != IDLE);

        if (key_vld_i) begin
            key_d        = key_i;
            key_loaded_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (chal_vld_i) begin
                    chal_d  = chal_i;
                    state_d = (key_loaded_q || key_vld_i) ? CALC : WAIT_KEY;
                end
            end
            WAIT_KEY: begin
                if (key_vld_i)               state_d = CALC;
                else if (cnt_q == KEY_LAST)  state_d = ERR;
                else                         cnt_d   = cnt_q + 1'b1;
            end
            CALC: begin
                // key_q already holds any key that arrived with the challenge
                c2_d    = chal_q ^ key_q;
                state_d = SEND;
            end
            SEND: begin
                // an ack only counts once the consumer has seen valid high
                if (c2_vld_q && c2_ack_i) begin
                    state_d    = IDLE;
                    resp_cnt_d = resp_cnt_q + 8'd1;
                end else if (cnt_q == ACK_LAST) begin
                    state_d = ERR;
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                    c2_vld_d = 1'b1;
                end
            end
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        err_d  = (state_d == ERR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            key_q        <= '0;
            key_loaded_q <= 1'b0;
            chal_q       <= '0;
            c2_q         <= '0;
            cnt_q        <= '0;
            c2_vld_q     <= 1'b0;
            busy_q       <= 1'b0;
            drop_q       <= 1'b0;
            err_q        <= 1'b0;
            resp_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            key_loaded_q <= key_loaded_d;
            chal_q       <= chal_d;
            c2_q         <= c2_d;
            cnt_q        <= cnt_d;
            c2_vld_q     <= c2_vld_d;
            busy_q       <= busy_d;
            drop_q       <= drop_d;
            err_q        <= err_d;
            resp_cnt_q   <= resp_cnt_d;
        end
    end

    assign c2_o       = c2_q;
    assign c2_vld_o   = c2_vld_q;
    assign busy_o     = busy_q;
    assign drop_o     = drop_q;
    assign err_o      = err_q;
    assign resp_cnt_o = resp_cnt_q;

endmodule

// File: tb/tb_challenge_responder.sv
// Bench for challenge_responder: directed corner cases plus randomized transactions
// checked against a transaction-level model (current key, key-loaded flag, ack count).
module tb_challenge_responder;

    localparam int W      = 4;
    localparam int KEY_TO = 15;
    localparam int ACK_TO = 15;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] key_i = '0;
    logic         key_vld_i = 1'b0;
    logic [W-1:0] chal_i = '0;
    logic         chal_vld_i = 1'b0;
    logic [W-1:0] c2_o;
    logic         c2_vld_o;
    logic         c2_ack_i = 1'b0;
    logic         busy_o;
    logic         drop_o;
    logic         err_o;
    logic [7:0]   resp_cnt_o;

    int n_chk = 0;
    int n_err = 0;

    logic [W-1:0] m_key    = '0;
    bit           m_loaded = 1'b0;
    logic [7:0]   m_resp   = '0;

    challenge_responder #(.WIDTH(W), .KEY_TO(KEY_TO), .ACK_TO(ACK_TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_i      (key_i),
        .key_vld_i  (key_vld_i),
        .chal_i     (chal_i),
        .chal_vld_i (chal_vld_i),
        .c2_o       (c2_o),
        .c2_vld_o   (c2_vld_o),
        .c2_ack_i   (c2_ack_i),
        .busy_o     (busy_o),
        .drop_o     (drop_o),
        .err_o      (err_o),
        .resp_cnt_o (resp_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_c2"},    32'(c2_o), 0);
        chk({tag, "_vld"},   32'(c2_vld_o), 0);
        chk({tag, "_busy"},  32'(busy_o), 0);
        chk({tag, "_drop"},  32'(drop_o), 0);
        chk({tag, "_err"},   32'(err_o), 0);
        chk({tag, "_resp"},  32'(resp_cnt_o), 0);
    endtask

    // Reset asserted between edges; released so the very next edge can take a challenge.
    task automatic do_reset();
        rst = 1'b0;
        #2;
        chk_all_zero("rst");
        step();
        rst      = 1'b1;
        m_key    = '0;
        m_loaded = 1'b0;
        m_resp   = '0;
    endtask

    // One challenge from IDLE back to IDLE.
    // kdly: idle cycles in WAIT_KEY before the key arrives (>= KEY_TO means never).
    // adly: valid-high cycles before ack (> ACK_TO-2 means never; valid is up for ACK_TO-1 cycles).
    task automatic run_txn(input logic [W-1:0] ch, input bit key_now, input logic [W-1:0] kv,
                           input int kdly, input int adly,
                           input bit pk, input logic [W-1:0] pkv, input bit pc);
        logic [W-1:0] exp_c2;
        bit           go;
        chk("idle_busy", 32'(busy_o), 0);
        chal_i = ch;
        chal_vld_i = 1'b1;
        if (key_now) begin
            key_i = kv; key_vld_i = 1'b1; m_key = kv; m_loaded = 1'b1;
        end
        step();
        chal_vld_i = 1'b0;
        key_vld_i  = 1'b0;
        chk("acc_busy", 32'(busy_o), 1);
        chk("acc_drop", 32'(drop_o), 0);
        go = m_loaded;
        if (!m_loaded) begin
            if (kdly < KEY_TO) begin
                repeat (kdly) begin
                    step();
                    chk("wk_vld", 32'(c2_vld_o), 0);
                    chk("wk_err", 32'(err_o), 0);
                end
                key_i = kv; key_vld_i = 1'b1; m_key = kv; m_loaded = 1'b1;
                step();
                key_vld_i = 1'b0;
                go = 1'b1;
            end else begin
                repeat (KEY_TO - 1) begin
                    step();
                    chk("wk_err_early", 32'(err_o), 0);
                    chk("wk_busy", 32'(busy_o), 1);
                end
                step();
                chk("key_to_err", 32'(err_o), 1);
                chk("key_to_vld", 32'(c2_vld_o), 0);
                step();
                chk("key_to_err_pulse", 32'(err_o), 0);
                chk("key_to_idle", 32'(busy_o), 0);
            end
        end
        if (go) begin
            exp_c2 = ch ^ m_key;
            chk("calc_vld", 32'(c2_vld_o), 0);
            step();
            chk("send0_vld", 32'(c2_vld_o), 0);
            chk("c2_val", 32'(c2_o), 32'(exp_c2));
            step();
            chk("c2_vld_rise", 32'(c2_vld_o), 1);
            if (adly <= ACK_TO - 2) begin
                for (int i = 0; i < adly; i++) begin
                    if (i == 0 && pk) begin key_i = pkv; key_vld_i = 1'b1; m_key = pkv; end
                    if (i == 0 && pc) begin chal_i = ~ch; chal_vld_i = 1'b1; end
                    step();
                    key_vld_i = 1'b0;
                    chal_vld_i = 1'b0;
                    chk("send_vld", 32'(c2_vld_o), 1);
                    chk("send_c2_hold", 32'(c2_o), 32'(exp_c2));
                    chk("send_drop", 32'(drop_o), 32'(i == 0 && pc));
                end
                c2_ack_i = 1'b1;
                step();
                c2_ack_i = 1'b0;
                m_resp = m_resp + 8'd1;
                chk("ack_vld_drop", 32'(c2_vld_o), 0);
                chk("ack_idle", 32'(busy_o), 0);
                chk("ack_resp", 32'(resp_cnt_o), 32'(m_resp));
            end else begin
                repeat (ACK_TO - 2) begin
                    step();
                    chk("send_wait_vld", 32'(c2_vld_o), 1);
                end
                step();
                chk("ack_to_err", 32'(err_o), 1);
                chk("ack_to_vld", 32'(c2_vld_o), 0);
                chk("ack_to_resp", 32'(resp_cnt_o), 32'(m_resp));
                step();
                chk("ack_to_err_pulse", 32'(err_o), 0);
                chk("ack_to_idle", 32'(busy_o), 0);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        step();
        chk_all_zero("por");

        // Late key after challenge; then a full key timeout from an unloaded state.
        do_reset();
        run_txn(4'b0011, 1'b0, 4'b0101, 5, 1, 1'b0, '0, 1'b0);
        chk("late_key_c2", 32'(c2_o), 32'(4'b0110));
        do_reset();
        run_txn(4'b0011, 1'b0, 4'b0000, KEY_TO, 0, 1'b0, '0, 1'b0);

        // Key arriving with the challenge on the first edge after reset release.
        do_reset();
        run_txn(4'b0110, 1'b1, 4'b1010, 0, 2, 1'b0, '0, 1'b0);
        chk("basic_c2", 32'(c2_o), 32'(4'b1100));
        chk("basic_resp", 32'(resp_cnt_o), 1);

        // Ack timeout, then key/challenge pokes during SEND.
        run_txn(4'b1001, 1'b0, '0, 0, ACK_TO, 1'b0, '0, 1'b0);
        run_txn(4'b0101, 1'b0, '0, 0, 3, 1'b1, 4'b1111, 1'b1);
        run_txn(4'b0000, 1'b0, '0, 0, 0, 1'b0, '0, 1'b0);
        chk("poked_key_used", 32'(c2_o), 32'(4'b1111));

        // Ack while idle is ignored.
        c2_ack_i = 1'b1;
        step();
        c2_ack_i = 1'b0;
        chk("stray_ack_resp", 32'(resp_cnt_o), 32'(m_resp));
        chk("stray_ack_busy", 32'(busy_o), 0);

        // Randomized transactions.
        for (int t = 0; t < 150; t++) begin
            run_txn(W'($urandom), ($urandom_range(0, 2) == 0), W'($urandom),
                    $urandom_range(0, KEY_TO + 1), $urandom_range(0, ACK_TO),
                    ($urandom_range(0, 3) == 0), W'($urandom), ($urandom_range(0, 3) == 0));
        end

        // Counter wrap after 256 acknowledged responses.
        do_reset();
        for (int t = 0; t < 256; t++)
            run_txn(W'($urandom), (t == 0), 4'b0111, 0, 0, 1'b0, '0, 1'b0);
        chk("resp_wrap", 32'(resp_cnt_o), 0);

        // Reset mid-SEND clears everything at once and credits nothing.
        run_txn(4'b0001, 1'b0, '0, 0, 0, 1'b0, '0, 1'b0);
        chal_i = 4'b0101; chal_vld_i = 1'b1;
        step();
        chal_vld_i = 1'b0;
        step();
        step();
        chk("pre_rst_vld", 32'(c2_vld_o), 1);
        #2;
        rst = 1'b0;
        c2_ack_i = 1'b1;
        #1;
        chk_all_zero("mid_send_rst");
        step();
        c2_ack_i = 1'b0;
        rst = 1'b1;
        step();
        chk("post_rst_resp", 32'(resp_cnt_o), 0);
        chk("post_rst_busy", 32'(busy_o), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/challenge_responder.md
CHALLENGE_RESPONDER -- requirements
Module: challenge_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data width of key, challenge and response.
REQ-002 SHALL have parameter KEY_TO, default 15, max cycles in WAIT_KEY before error.
REQ-003 SHALL have parameter ACK_TO, default 15, max cycles in SEND before error.
REQ-004 SHALL have port clk  input  1  clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port key_i  input  WIDTH  shared secret from key exchange.
REQ-007 SHALL have port key_vld_i  input  1  key_i valid strobe.
REQ-008 SHALL have port chal_i  input  WIDTH  challenge r_1 from checker side.
REQ-009 SHALL have port chal_vld_i  input  1  chal_i valid strobe.
REQ-010 SHALL have port c2_o  output  WIDTH  response c_2 = r_1 XOR key.
REQ-011 SHALL have port c2_vld_o  output  1  c2_o valid, held until ack.
REQ-012 SHALL have port c2_ack_i  input  1  consumer accepted c2_o.
REQ-013 SHALL have port busy_o  output  1  high in any state other than IDLE.
REQ-014 SHALL have port drop_o  output  1  one-cycle pulse: challenge ignored.
REQ-015 SHALL have port err_o  output  1  one-cycle pulse: timeout.
REQ-016 SHALL have port resp_cnt_o  output  8  count of acknowledged responses.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT_KEY, CALC, SEND, ERR; all outputs registered.
REQ-018 SHALL latch key_i into key register and set key_loaded flag whenever key_vld_i=1, in any state.
REQ-019 IDLE: chal_vld_i=1 latches chal_i; next state CALC if key_loaded=1 or key_vld_i=1 same cycle, else WAIT_KEY.
REQ-020 Simultaneous key_vld_i and chal_vld_i in IDLE SHALL use the new key_i.
REQ-021 WAIT_KEY: key_vld_i=1 -> CALC; wait counter reaching KEY_TO without key -> ERR.
REQ-022 CALC: one cycle; c2 register loaded with challenge XOR key (bitwise, WIDTH bits); -> SEND.
REQ-023 Latency: chal_vld_i sampled at edge N in IDLE with key loaded -> c2_vld_o=1 after edge N+2.
REQ-024 SEND: c2_vld_o=1, c2_o stable; c2_ack_i=1 -> IDLE, c2_vld_o=0 next cycle, resp_cnt_o+1.
REQ-025 resp_cnt_o SHALL wrap 255 -> 0.
REQ-026 SEND: counter reaching ACK_TO without ack -> ERR; resp_cnt_o unchanged.
REQ-027 key_vld_i during SEND SHALL update key register but SHALL NOT alter c2_o.
REQ-028 ERR: err_o=1 for exactly one cycle, c2_vld_o=0 -> IDLE; key_loaded retained.
REQ-029 chal_vld_i=1 in any state but IDLE SHALL be ignored and pulse drop_o next cycle.
REQ-030 c2_ack_i outside SEND SHALL be ignored.
REQ-031 Timeout counter SHALL clear on every state entry; width ceil(log2(max(KEY_TO,ACK_TO)+1)).

Reset
REQ-032 rst=0 SHALL asynchronously force IDLE, clear key, challenge, c2_o, key_loaded, counters, all outputs to 0.
REQ-033 Reset mid-SEND SHALL drop c2_vld_o immediately; no ack credited.
REQ-034 First cycle after rst release SHALL accept chal_vld_i.

Structure
REQ-035 State encoding and default WIDTH/KEY_TO/ACK_TO SHALL live in shared package dh_pkg.
REQ-036 Single flat module; no sub-module; XOR computed inline in CALC.

Verification
REQ-037 key=4'b1010 loaded, chal=4'b0110 -> c2_o=4'b1100, c2_vld_o high 2 cycles later; ack -> resp_cnt_o=1; feeding c2_o to checker gives true_2=1.
REQ-038 chal=4'b0011 with no key; key 4'b0101 after 5 cycles -> c2_o=4'b0110; no key for 15 cycles -> err_o pulse, state IDLE.
REQ-039 SEND with no ack for ACK_TO cycles -> err_o pulse, c2_vld_o=0, resp_cnt_o unchanged.
REQ-040 chal_vld_i during SEND -> drop_o pulse, c2_o unchanged; key_vld_i 4'b1111 during SEND -> c2_o unchanged.
REQ-041 256 acked transactions -> resp_cnt_o=0; rst low mid-SEND -> all outputs 0 immediately.
